// File: rtl/fp_acc_sat.sv
// Block accumulator for the S(9,8) product stream: sums ACC_LEN samples and emits a saturated S(NB_OUT,NBF_OUT) result.
// Define FP_ACC_ROUND_EN for round-half-up fraction reduction; the default build truncates (floor).
module fp_acc_sat #(
    parameter int NB_IN   = 9,
    parameter int NBF_IN  = 8,
    parameter int ACC_LEN = 16,
    parameter int NB_OUT  = 10,
    parameter int NBF_OUT = 7
) (
    input  logic              clk,
    input  logic              i_rst_n,
    input  logic              i_clear,
    input  logic [NB_IN-1:0]  i_data,
    input  logic              i_valid,
    output logic              o_in_ready,
    output logic [NB_OUT-1:0] o_data,
    output logic              o_valid,
    input  logic              i_out_ready,
    output logic              o_sat
);

    localparam int NB_CNT = $clog2(ACC_LEN);
    localparam int NB_ACC = NB_IN + NB_CNT;
    localparam int SHIFT  = NBF_IN - NBF_OUT;
    // One spare MSB over the accumulator so a rounding carry can never wrap.
    localparam int NW     = (NB_ACC > NB_OUT) ? NB_ACC + 1 : NB_OUT + 1;

    localparam logic signed [NW-1:0] SAT_MAX = NW'((64'sd1 <<< (NB_OUT - 1)) - 64'sd1);
    localparam logic signed [NW-1:0] SAT_MIN = NW'(-(64'sd1 <<< (NB_OUT - 1)));

    typedef enum logic [1:0] {ST_ACC, ST_CVT, ST_HOLD} state_t;

    state_t                    state;
    logic signed [NB_ACC-1:0]  acc;
    logic [NB_CNT-1:0]         cnt;
    logic signed [NW-1:0]      acc_w;
    logic signed [NW-1:0]      cvt_w;
    logic [NB_OUT-1:0]         cvt_data;
    logic                      cvt_sat;

    assign o_in_ready = (state == ST_ACC);

`ifdef FP_ACC_ROUND_EN
    localparam logic signed [NW-1:0] RND = NW'((64'sd1 <<< SHIFT) >>> 1);
`endif

    always_comb begin
        acc_w = NW'(acc);
`ifdef FP_ACC_ROUND_EN
        cvt_w = (acc_w + RND) >>> SHIFT;
`else
        cvt_w = acc_w >>> SHIFT;
`endif
        cvt_data = cvt_w[NB_OUT-1:0];
        cvt_sat  = 1'b0;
        if (cvt_w > SAT_MAX) begin
            cvt_data = SAT_MAX[NB_OUT-1:0];
            cvt_sat  = 1'b1;
        end else if (cvt_w < SAT_MIN) begin
            cvt_data = SAT_MIN[NB_OUT-1:0];
            cvt_sat  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state   <= ST_ACC;
            acc     <= '0;
            cnt     <= '0;
            o_data  <= '0;
            o_valid <= 1'b0;
            o_sat   <= 1'b0;
        end else if (i_clear) begin
            state   <= ST_ACC;
            acc     <= '0;
            cnt     <= '0;
            o_valid <= 1'b0;
            o_sat   <= 1'b0;
        end else begin
            case (state)
                ST_ACC: begin
                    if (i_valid) begin
                        acc <= acc + NB_ACC'($signed(i_data));
                        cnt <= cnt + 1'b1;
                        if (cnt == NB_CNT'(ACC_LEN - 1)) state <= ST_CVT;
                    end
                end
                ST_CVT: begin
                    o_data  <= cvt_data;
                    o_sat   <= cvt_sat;
                    o_valid <= 1'b1;
                    state   <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (i_out_ready) begin
                        o_valid <= 1'b0;
                        acc     <= '0;
                        state   <= ST_ACC;
                    end
                end
                default: state <= ST_ACC;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_acc_sat.sv
// Directed bench for fp_acc_sat; expected values are hand-computed for both FP_ACC_ROUND_EN builds.
module tb_fp_acc_sat;

    logic       clk;
    logic       i_rst_n;
    logic       i_clear;
    logic [8:0] i_data;
    logic       i_valid;
    logic       o_in_ready;
    logic [9:0] o_data;
    logic       o_valid;
    logic       i_out_ready;
    logic       o_sat;

    int unsigned total = 0;
    int unsigned bad   = 0;

    fp_acc_sat #(
        .NB_IN  (9),
        .NBF_IN (8),
        .ACC_LEN(16),
        .NB_OUT (10),
        .NBF_OUT(7)
    ) dut (
        .clk        (clk),
        .i_rst_n    (i_rst_n),
        .i_clear    (i_clear),
        .i_data     (i_data),
        .i_valid    (i_valid),
        .o_in_ready (o_in_ready),
        .o_data     (o_data),
        .o_valid    (o_valid),
        .i_out_ready(i_out_ready),
        .o_sat      (o_sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // first sample `first`, remaining ACC_LEN-1 samples `rest`; leaves the DUT in CVT
    task automatic feed(input logic [8:0] first, input logic [8:0] rest);
        for (int i = 0; i < 16; i++) begin
            i_valid = 1'b1;
            i_data  = (i == 0) ? first : rest;
            tick();
        end
        i_valid = 1'b0;
    endtask

    // CVT then HOLD checks; with ready high the result is a single-cycle pulse
    task automatic finish_block(input string tag, input logic [9:0] exp_d, input logic exp_s);
        chk({tag, "_cvt_valid"}, {31'd0, o_valid}, 32'd0);
        chk({tag, "_cvt_ready"}, {31'd0, o_in_ready}, 32'd0);
        tick();
        chk({tag, "_valid"}, {31'd0, o_valid}, 32'd1);
        chk({tag, "_data"}, {22'd0, o_data}, {22'd0, exp_d});
        chk({tag, "_sat"}, {31'd0, o_sat}, {31'd0, exp_s});
        if (i_out_ready) begin
            tick();
            chk({tag, "_drop"}, {31'd0, o_valid}, 32'd0);
            chk({tag, "_inrdy"}, {31'd0, o_in_ready}, 32'd1);
        end
    endtask

    initial begin
        logic [9:0] exp_pos_lsb;
        logic [9:0] exp_neg_lsb;
`ifdef FP_ACC_ROUND_EN
        exp_pos_lsb = 10'h001;
        exp_neg_lsb = 10'h000;
`else
        exp_pos_lsb = 10'h000;
        exp_neg_lsb = 10'h3FF;
`endif
        i_rst_n     = 1'b0;
        i_clear     = 1'b0;
        i_data      = '0;
        i_valid     = 1'b0;
        i_out_ready = 1'b1;
        #1;
        chk("rst_data", {22'd0, o_data}, 32'd0);
        chk("rst_valid", {31'd0, o_valid}, 32'd0);
        chk("rst_sat", {31'd0, o_sat}, 32'd0);
        tick();
        tick();
        #2 i_rst_n = 1'b1;
        tick();
        chk("rst_inrdy", {31'd0, o_in_ready}, 32'd1);

        feed(9'h020, 9'h020);
        finish_block("b_2p0", 10'h100, 1'b0);
        feed(9'h080, 9'h080);
        finish_block("b_possat", 10'h1FF, 1'b1);
        feed(9'h100, 9'h100);
        finish_block("b_negsat", 10'h200, 1'b1);
        feed(9'h001, 9'h000);
        finish_block("b_poslsb", exp_pos_lsb, 1'b0);
        feed(9'h1FF, 9'h000);
        finish_block("b_neglsb", exp_neg_lsb, 1'b0);

        // backpressure: samples offered during HOLD must be ignored
        i_out_ready = 1'b0;
        feed(9'h020, 9'h020);
        finish_block("bp", 10'h100, 1'b0);
        for (int i = 0; i < 5; i++) begin
            i_valid = 1'b1;
            i_data  = 9'h080;
            tick();
            chk("bp_hold_valid", {31'd0, o_valid}, 32'd1);
            chk("bp_hold_data", {22'd0, o_data}, 32'h100);
            chk("bp_hold_inrdy", {31'd0, o_in_ready}, 32'd0);
        end
        i_valid     = 1'b0;
        i_out_ready = 1'b1;
        tick();
        chk("bp_release", {31'd0, o_valid}, 32'd0);
        feed(9'h010, 9'h010);
        finish_block("bp_next", 10'h080, 1'b0);

        // clear mid-block beats a simultaneous valid sample
        for (int i = 0; i < 7; i++) begin
            i_valid = 1'b1;
            i_data  = 9'h020;
            tick();
        end
        i_clear = 1'b1;
        i_data  = 9'h07F;
        tick();
        i_clear = 1'b0;
        i_valid = 1'b0;
        feed(9'h020, 9'h020);
        finish_block("clr_blk", 10'h100, 1'b0);

        // clear in HOLD beats a simultaneous accept
        i_out_ready = 1'b0;
        feed(9'h080, 9'h080);
        finish_block("clr_hold", 10'h1FF, 1'b1);
        i_clear     = 1'b1;
        i_out_ready = 1'b1;
        tick();
        i_clear = 1'b0;
        chk("clr_hold_valid", {31'd0, o_valid}, 32'd0);
        chk("clr_hold_sat", {31'd0, o_sat}, 32'd0);
        chk("clr_hold_data", {22'd0, o_data}, 32'h1FF);
        chk("clr_hold_inrdy", {31'd0, o_in_ready}, 32'd1);

        // async reset between edges while holding a result
        i_out_ready = 1'b0;
        feed(9'h080, 9'h080);
        finish_block("ar_hold", 10'h1FF, 1'b1);
        #2 i_rst_n = 1'b0;
        #1;
        chk("ar_hold_valid", {31'd0, o_valid}, 32'd0);
        chk("ar_hold_data", {22'd0, o_data}, 32'd0);
        chk("ar_hold_sat", {31'd0, o_sat}, 32'd0);
        #1 i_rst_n = 1'b1;
        i_out_ready = 1'b1;
        tick();

        // async reset mid-block discards the partial sum
        for (int i = 0; i < 5; i++) begin
            i_valid = 1'b1;
            i_data  = 9'h080;
            tick();
        end
        i_valid = 1'b0;
        #2 i_rst_n = 1'b0;
        #1 chk("ar_blk_inrdy", {31'd0, o_in_ready}, 32'd1);
        #1 i_rst_n = 1'b1;
        tick();
        feed(9'h020, 9'h020);
        finish_block("ar_next", 10'h100, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
